// File: rtl/baud_prescaler_pkg.sv
// Shared types and constants for the baud prescaler: autobaud state encoding,
// default widths and the millisecond / blink timing helpers.
package baud_prescaler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FALL = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } ab_state_t;

  localparam int DIV_W_DEF      = 8;
  localparam int CNT_W_DEF      = 12;
  localparam int CAL_TIMEOUT_MS = 1000;

  function automatic int ms_cycles(input int clkrate);
    return clkrate / 1000;
  endfunction

  function automatic int blink_ms();
    return 500;
  endfunction

endpackage

// File: rtl/baud_prescaler_if.sv
// Signal bundle between the prescaler and its surroundings; the slave modport
// is the prescaler side.
interface baud_prescaler_if
  import baud_prescaler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) ();
  // cal_start and uart_tick are single-cycle pulses; everything else is level.
  logic             rx;
  logic             cal_start;
  logic             uart_tick;
  logic             uart_clk;
  logic             blink;
  logic             link;
  logic             locked;
  logic             cal_fail;
  logic [DIV_W-1:0] divisor;
  ab_state_t        state;

  modport master (
    output rx, cal_start,
    input  uart_tick, uart_clk, blink, link, locked, cal_fail, divisor, state
  );

  modport slave (
    input  rx, cal_start,
    output uart_tick, uart_clk, blink, link, locked, cal_fail, divisor, state
  );
endinterface

// File: rtl/baud_prescaler_autobaud_meter.sv
// Autobaud: measures the shortest of PULSES rx low pulses and turns it into a
// baud divisor; falls back to the default divisor on timeout or overlong pulse.
module autobaud_meter
  import baud_prescaler_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PULSES     = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_DIV    = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_rx_s,
  input  logic             i_rx_d,
  input  logic             i_ms_tick,
  input  logic             i_cal_start,
  output logic [DIV_W-1:0] o_divisor_new,
  output logic             o_locked,
  output logic             o_cal_fail,
  output ab_state_t        o_state
);
  localparam int OS_SH = $clog2(OVERSAMPLE);
  localparam int D_MAX = (1 << DIV_W) - 1;
  localparam int PC_W  = $clog2(PULSES + 1);
  localparam int TO_W  = $clog2(CAL_TIMEOUT_MS);

  ab_state_t        r_state;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_min;
  logic [PC_W-1:0]  r_pulses;
  logic [TO_W-1:0]  r_to;
  logic [DIV_W-1:0] r_div_new;
  logic             r_locked;
  logic             r_cal_fail;

  logic             w_fall;
  logic             w_rise;
  logic [CNT_W-1:0] w_min_next;
  logic [31:0]      w_sh32;
  logic [DIV_W-1:0] w_div_calc;

  assign w_fall     = ~i_rx_s & i_rx_d;
  assign w_rise     = i_rx_s & ~i_rx_d;
  assign w_min_next = (r_width < r_min) ? r_width : r_min;
  assign w_sh32     = 32'(r_min) >> OS_SH;

  // Divisor is clamped to [2, 2^DIV_W-1] so the baud counter always wraps.
  always_comb begin
    w_div_calc = DIV_W'(w_sh32);
    if (w_sh32 < 32'd2)               w_div_calc = DIV_W'(2);
    else if (w_sh32 > 32'(D_MAX))     w_div_calc = DIV_W'(D_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_width    <= '0;
      r_min      <= '0;
      r_pulses   <= '0;
      r_to       <= '0;
      r_div_new  <= DIV_W'(DEF_DIV);
      r_locked   <= 1'b0;
      r_cal_fail <= 1'b0;
    end else if (i_cal_start) begin
      r_state    <= ST_WAIT_FALL;
      r_min      <= '1;
      r_pulses   <= '0;
      r_to       <= '0;
      r_locked   <= 1'b0;
      r_cal_fail <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_WAIT_FALL: begin
          if (w_fall) begin
            r_state <= ST_MEASURE;
            r_width <= CNT_W'(1);
          end else if (i_ms_tick) begin
            if (r_to == TO_W'(CAL_TIMEOUT_MS - 1)) r_state <= ST_FAIL;
            else                                   r_to    <= r_to + TO_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_min    <= w_min_next;
            r_pulses <= r_pulses + PC_W'(1);
            r_to     <= '0;
            if (r_pulses == PC_W'(PULSES - 1)) r_state <= ST_LOCKED;
            else                               r_state <= ST_WAIT_FALL;
          end else if (r_width == '1) begin
            r_state <= ST_FAIL;
          end else if (!i_rx_s) begin
            r_width <= r_width + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          r_locked  <= 1'b1;
          r_div_new <= w_div_calc;
        end
        ST_FAIL: begin
          r_cal_fail <= 1'b1;
          r_div_new  <= DIV_W'(DEF_DIV);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_divisor_new = r_div_new;
  assign o_locked      = r_locked;
  assign o_cal_fail    = r_cal_fail;
  assign o_state       = r_state;

endmodule

// File: rtl/baud_prescaler.sv
// Oversampling baud tick/clock generator with blink, rx link indicator and
// run-time autobaud; divisor changes are applied only at a baud-counter wrap.
module baud_prescaler
  import baud_prescaler_pkg::*;
#(
  parameter int CLKRATE    = 12_000_000,
  parameter int BAUDRATE   = 57_600,
  parameter int OVERSAMPLE = 16,
  parameter int LINK_MS    = 64,
  parameter int PULSES     = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  baud_prescaler_if.slave  bus
);
  localparam int DIVISOR = CLKRATE / BAUDRATE / OVERSAMPLE;
  localparam int MS_CYC  = ms_cycles(CLKRATE);
  localparam int MS_W    = $clog2(MS_CYC + 1);
  localparam int BL_MS   = blink_ms();
  localparam int BL_W    = $clog2(BL_MS + 1);
  localparam int LK_W    = $clog2(LINK_MS + 1);

  logic             r_rx_m, r_rx_s, r_rx_d;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_divisor;
  logic             r_tick, r_uclk;
  logic [MS_W-1:0]  r_ms_cnt;
  logic             r_ms_tick;
  logic [BL_W-1:0]  r_bl_cnt;
  logic             r_blink;
  logic [LK_W-1:0]  r_link_cnt;
  logic             r_link;

  logic             w_edge;
  logic [DIV_W-1:0] w_div_new;
  logic             w_locked, w_cal_fail;
  ab_state_t        w_state;

  assign w_edge = r_rx_s ^ r_rx_d;

  // Synchroniser resets to the idle line level so reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= bus.rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_divisor <= DIV_W'(DIVISOR);
      r_tick    <= 1'b0;
      r_uclk    <= 1'b0;
    end else begin
      r_tick <= (r_cnt == '0);
      r_uclk <= (r_cnt < (r_divisor >> 1));
      if (r_cnt == '0) begin
        r_divisor <= w_div_new;
        r_cnt     <= w_div_new - DIV_W'(1);
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_cnt  <= '0;
      r_ms_tick <= 1'b0;
      r_bl_cnt  <= '0;
      r_blink   <= 1'b0;
    end else begin
      if (r_ms_cnt == MS_W'(MS_CYC - 1)) begin
        r_ms_cnt  <= '0;
        r_ms_tick <= 1'b1;
      end else begin
        r_ms_cnt  <= r_ms_cnt + MS_W'(1);
        r_ms_tick <= 1'b0;
      end
      if (r_ms_tick) begin
        if (r_bl_cnt == BL_W'(BL_MS - 1)) begin
          r_bl_cnt <= '0;
          r_blink  <= ~r_blink;
        end else begin
          r_bl_cnt <= r_bl_cnt + BL_W'(1);
        end
      end
    end
  end

  // An edge coinciding with ms_tick reloads rather than decrements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_link_cnt <= '0;
      r_link     <= 1'b0;
    end else begin
      if (w_edge)                               r_link_cnt <= LK_W'(LINK_MS);
      else if (r_ms_tick && r_link_cnt != '0)   r_link_cnt <= r_link_cnt - LK_W'(1);
      r_link <= (r_link_cnt != '0);
    end
  end

  autobaud_meter #(
    .OVERSAMPLE (OVERSAMPLE),
    .PULSES     (PULSES),
    .DIV_W      (DIV_W),
    .CNT_W      (CNT_W),
    .DEF_DIV    (DIVISOR)
  ) u_meter (
    .clk           (clk),
    .reset         (reset),
    .i_rx_s        (r_rx_s),
    .i_rx_d        (r_rx_d),
    .i_ms_tick     (r_ms_tick),
    .i_cal_start   (bus.cal_start),
    .o_divisor_new (w_div_new),
    .o_locked      (w_locked),
    .o_cal_fail    (w_cal_fail),
    .o_state       (w_state)
  );

  assign bus.uart_tick = r_tick;
  assign bus.uart_clk  = r_uclk;
  assign bus.blink     = r_blink;
  assign bus.link      = r_link;
  assign bus.locked    = w_locked;
  assign bus.cal_fail  = w_cal_fail;
  assign bus.divisor   = r_divisor;
  assign bus.state     = w_state;

endmodule

// File: tb/tb_baud_prescaler.sv
// Directed bench for baud_prescaler, scaled to a 12 kHz clock so 1 ms = 12 clk
// while the default divisor stays 13 (12000/57/16).
module tb_baud_prescaler;
  import baud_prescaler_pkg::*;

  localparam int MS = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  baud_prescaler_if #(.DIV_W(8)) bus ();

  baud_prescaler #(
    .CLKRATE    (12_000),
    .BAUDRATE   (57),
    .OVERSAMPLE (16),
    .LINK_MS    (64),
    .PULSES     (4),
    .DIV_W      (8),
    .CNT_W      (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_cal();
    bus.cal_start = 1'b1;
    @(negedge clk);
    bus.cal_start = 1'b0;
  endtask

  task automatic low_pulse(input int lo, input int hi);
    bus.rx = 1'b0;
    repeat (lo) @(negedge clk);
    bus.rx = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bl);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      repeat (bl) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    bus.cal_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.uart_tick !== 1'b0) begin failures++; $display("FAIL rst_uart_tick got=%0b exp=0", bus.uart_tick); end
    checks++; if (bus.uart_clk !== 1'b0) begin failures++; $display("FAIL rst_uart_clk got=%0b exp=0", bus.uart_clk); end
    checks++; if (bus.blink !== 1'b0) begin failures++; $display("FAIL rst_blink got=%0b exp=0", bus.blink); end
    checks++; if (bus.link !== 1'b0) begin failures++; $display("FAIL rst_link got=%0b exp=0", bus.link); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0b exp=0", bus.locked); end
    checks++; if (bus.cal_fail !== 1'b0) begin failures++; $display("FAIL rst_cal_fail got=%0b exp=0", bus.cal_fail); end
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL rst_divisor got=%0d exp=13", bus.divisor); end
    checks++; if (bus.state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", int'(bus.state), int'(ST_IDLE)); end
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    int n, hi;
    n = 0;
    while (bus.uart_tick !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL def_first_tick got=none exp=tick"); end
    for (int p = 0; p < 3; p++) begin
      n = 0; hi = 0;
      do begin
        @(negedge clk); n++;
        if (bus.uart_clk === 1'b1) hi++;
      end while (bus.uart_tick !== 1'b1 && n < 100);
      checks++; if (n !== 13) begin failures++; $display("FAIL def_tick_period got=%0d exp=13", n); end
      checks++; if (hi !== 6) begin failures++; $display("FAIL def_uart_clk_high got=%0d exp=6", hi); end
    end
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL def_divisor got=%0d exp=13", bus.divisor); end
  endtask

  task automatic test_blink();
    logic b0;
    int n;
    b0 = bus.blink;
    n = 0;
    while (bus.blink === b0 && n < 7000) begin @(negedge clk); n++; end
    checks++; if (n >= 7000) begin failures++; $display("FAIL blink_first_toggle got=none exp=toggle"); end
    checks++; if (bus.blink !== 1'b1) begin failures++; $display("FAIL blink_first_value got=%0b exp=1", bus.blink); end
    b0 = bus.blink;
    n = 0;
    while (bus.blink === b0 && n < 7000) begin @(negedge clk); n++; end
    checks++; if (n !== 500 * MS) begin failures++; $display("FAIL blink_period got=%0d exp=%0d", n, 500 * MS); end
  endtask

  task automatic test_link_single();
    int n;
    checks++; if (bus.link !== 1'b0) begin failures++; $display("FAIL link_idle got=%0b exp=0", bus.link); end
    bus.rx = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.link !== 1'b1 && n < 20);
    checks++; if (n !== 4) begin failures++; $display("FAIL link_latency got=%0d exp=4", n); end
    repeat (62 * MS) @(negedge clk);
    checks++; if (bus.link !== 1'b1) begin failures++; $display("FAIL link_hold_62ms got=%0b exp=1", bus.link); end
    repeat (3 * MS) @(negedge clk);
    checks++; if (bus.link !== 1'b0) begin failures++; $display("FAIL link_drop_65ms got=%0b exp=0", bus.link); end
  endtask

  task automatic test_link_extend();
    bus.rx = 1'b1;
    repeat (60 * MS) @(negedge clk);
    checks++; if (bus.link !== 1'b1) begin failures++; $display("FAIL link_ext_60ms got=%0b exp=1", bus.link); end
    bus.rx = 1'b0;
    repeat (40 * MS) @(negedge clk);
    checks++; if (bus.link !== 1'b1) begin failures++; $display("FAIL link_ext_100ms got=%0b exp=1", bus.link); end
    repeat (30 * MS) @(negedge clk);
    checks++; if (bus.link !== 1'b0) begin failures++; $display("FAIL link_ext_130ms got=%0b exp=0", bus.link); end
    bus.rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_autobaud_115200();
    int bad, n13, n6, last;
    bad = 0; n13 = 0; n6 = 0; last = -1;
    fork
      begin
        pulse_cal();
        send_byte(8'h55, 104);
        repeat (100) @(negedge clk);
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk);
          if (bus.uart_tick === 1'b1) begin
            if (last >= 0) begin
              if (c - last == 13) n13++;
              else if (c - last == 6) n6++;
              else bad++;
            end
            last = c;
          end
        end
      end
    join
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL ab115_locked got=%0b exp=1", bus.locked); end
    checks++; if (bus.divisor !== 8'd6) begin failures++; $display("FAIL ab115_divisor got=%0d exp=6", bus.divisor); end
    checks++; if (bus.cal_fail !== 1'b0) begin failures++; $display("FAIL ab115_cal_fail got=%0b exp=0", bus.cal_fail); end
    checks++; if (bus.state !== ST_LOCKED) begin failures++; $display("FAIL ab115_state got=%0d exp=%0d", int'(bus.state), int'(ST_LOCKED)); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ab115_truncated_periods got=%0d exp=0", bad); end
    checks++; if (n13 == 0 || n6 == 0) begin failures++; $display("FAIL ab115_switch got=n13:%0d,n6:%0d exp=both>0", n13, n6); end
  endtask

  task automatic test_autobaud_19200();
    pulse_cal();
    send_byte(8'h55, 625);
    repeat (60) @(negedge clk);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL ab19k_locked got=%0b exp=1", bus.locked); end
    checks++; if (bus.divisor !== 8'd39) begin failures++; $display("FAIL ab19k_divisor got=%0d exp=39", bus.divisor); end
  endtask

  task automatic test_autobaud_2400();
    pulse_cal();
    bus.rx = 1'b0;
    repeat (4000) @(negedge clk);
    checks++; if (bus.cal_fail !== 1'b0) begin failures++; $display("FAIL ab2k4_early_fail got=%0b exp=0", bus.cal_fail); end
    checks++; if (bus.state !== ST_MEASURE) begin failures++; $display("FAIL ab2k4_measuring got=%0d exp=%0d", int'(bus.state), int'(ST_MEASURE)); end
    repeat (1000) @(negedge clk);
    checks++; if (bus.cal_fail !== 1'b1) begin failures++; $display("FAIL ab2k4_cal_fail got=%0b exp=1", bus.cal_fail); end
    checks++; if (bus.state !== ST_FAIL) begin failures++; $display("FAIL ab2k4_state got=%0d exp=%0d", int'(bus.state), int'(ST_FAIL)); end
    bus.rx = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL ab2k4_divisor got=%0d exp=13", bus.divisor); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL ab2k4_locked got=%0b exp=0", bus.locked); end
  endtask

  task automatic test_idle_timeout();
    pulse_cal();
    repeat (990 * MS) @(negedge clk);
    checks++; if (bus.cal_fail !== 1'b0) begin failures++; $display("FAIL idle_990ms got=%0b exp=0", bus.cal_fail); end
    checks++; if (bus.state !== ST_WAIT_FALL) begin failures++; $display("FAIL idle_waiting got=%0d exp=%0d", int'(bus.state), int'(ST_WAIT_FALL)); end
    repeat (20 * MS) @(negedge clk);
    checks++; if (bus.cal_fail !== 1'b1) begin failures++; $display("FAIL idle_1010ms got=%0b exp=1", bus.cal_fail); end
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL idle_divisor got=%0d exp=13", bus.divisor); end
  endtask

  task automatic test_restart();
    pulse_cal();
    low_pulse(50, 50);
    low_pulse(50, 50);
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (bus.state !== ST_MEASURE) begin failures++; $display("FAIL rs_mid_measure got=%0d exp=%0d", int'(bus.state), int'(ST_MEASURE)); end
    pulse_cal();
    checks++; if (bus.state !== ST_WAIT_FALL) begin failures++; $display("FAIL rs_restart_state got=%0d exp=%0d", int'(bus.state), int'(ST_WAIT_FALL)); end
    repeat (30) @(negedge clk);
    bus.rx = 1'b1;
    repeat (320) @(negedge clk);
    for (int i = 0; i < 3; i++) low_pulse(320, 320);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rs_three_pulses_locked got=%0b exp=0", bus.locked); end
    low_pulse(320, 320);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL rs_locked got=%0b exp=1", bus.locked); end
    checks++; if (bus.divisor !== 8'd20) begin failures++; $display("FAIL rs_divisor got=%0d exp=20", bus.divisor); end
  endtask

  task automatic test_reset_mid_measure();
    pulse_cal();
    low_pulse(104, 104);
    bus.rx = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (bus.state !== ST_MEASURE) begin failures++; $display("FAIL rm_pre_state got=%0d exp=%0d", int'(bus.state), int'(ST_MEASURE)); end
    checks++; if (bus.divisor !== 8'd20) begin failures++; $display("FAIL rm_pre_divisor got=%0d exp=20", bus.divisor); end
    #2 reset = 1'b1;
    bus.rx = 1'b1;
    #1;
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL rm_async_divisor got=%0d exp=13", bus.divisor); end
    checks++; if (bus.state !== ST_IDLE) begin failures++; $display("FAIL rm_async_state got=%0d exp=%0d", int'(bus.state), int'(ST_IDLE)); end
    checks++; if (bus.link !== 1'b0) begin failures++; $display("FAIL rm_async_link got=%0b exp=0", bus.link); end
    checks++; if (bus.blink !== 1'b0) begin failures++; $display("FAIL rm_async_blink got=%0b exp=0", bus.blink); end
    checks++; if (bus.uart_clk !== 1'b0 || bus.uart_tick !== 1'b0) begin failures++; $display("FAIL rm_async_uart got=%0b%0b exp=00", bus.uart_clk, bus.uart_tick); end
    checks++; if (bus.locked !== 1'b0 || bus.cal_fail !== 1'b0) begin failures++; $display("FAIL rm_async_flags got=%0b%0b exp=00", bus.locked, bus.cal_fail); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (bus.divisor !== 8'd13) begin failures++; $display("FAIL rm_post_divisor got=%0d exp=13", bus.divisor); end
    checks++; if (bus.state !== ST_IDLE) begin failures++; $display("FAIL rm_post_state got=%0d exp=%0d", int'(bus.state), int'(ST_IDLE)); end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.cal_start = 1'b0;
    test_reset();
    test_defaults();
    test_blink();
    test_link_single();
    test_link_extend();
    test_autobaud_115200();
    test_autobaud_19200();
    test_autobaud_2400();
    test_idle_timeout();
    test_restart();
    test_reset_mid_measure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
